// File: rtl/xiyiji_pkg.sv
// Shared seven-segment and digit-select constants for the wash-time display.
// Pure definitions; no logic, no latency, no flow control.
package xiyiji_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] DIG_UNITS = 2'b10;
  localparam logic [1:0] DIG_TENS  = 2'b01;
  localparam logic [1:0] DIG_NONE  = 2'b11;

  typedef enum logic {SLOT_UNITS = 1'b0, SLOT_TENS = 1'b1} slot_e;
  typedef enum logic {PH_ON = 1'b0, PH_OFF = 1'b1} phase_e;

endpackage

// File: rtl/seg7_dec.sv
// BCD digit to {a..g} active-high segments; codes 10..15 go blank.
// Combinational, zero latency, no flow control.
module seg7_dec
  import xiyiji_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/xiyiji_disp_scan.sv
// Two-digit multiplexed display scanner with frame snapshot, leading-zero blanking and alarm blink.
// Outputs registered; a count change shows at the next frame start (<= 2*SCAN_DIV+1 cycles); no backpressure.
module xiyiji_disp_scan
  import xiyiji_pkg::*;
#(
  parameter int SCAN_DIV  = 1,
  parameter int BLINK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] count,
  input  logic       alarm,
  output logic [6:0] discode,
  output logic [1:0] enable,
  output logic       frame
);

  localparam logic [9:0] TICK_LAST  = 10'(SCAN_DIV - 1);
  localparam logic [9:0] BLINK_LAST = 10'(BLINK_DIV - 1);

  logic [9:0] tick_q, tick_d;
  logic [9:0] blink_q, blink_d;
  slot_e      slot_q, slot_d;
  phase_e     phase_q, phase_d;
  logic [5:0] snap_q, snap_d;
  logic       alarm_q;
  logic [6:0] discode_q, discode_d;
  logic [1:0] enable_q, enable_d;
  logic       frame_q, frame_d;

  logic       scan_tick;
  logic       alarm_rise;
  logic [3:0] tens, units, digit;
  logic [6:0] seg;

  seg7_dec u_dec (
    .digit_i (digit),
    .seg_o   (seg)
  );

  always_comb begin
    scan_tick  = (tick_q == TICK_LAST);
    alarm_rise = alarm & ~alarm_q;
    tick_d     = scan_tick ? 10'd0 : tick_q + 10'd1;

    slot_d  = slot_q;
    frame_d = 1'b0;
    if (scan_tick) begin
      slot_d  = (slot_q == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
      frame_d = (slot_q == SLOT_TENS);
    end

    // The units slot of a new frame must already show the freshly captured value.
    snap_d = frame_d ? count : snap_q;
    tens   = 4'(snap_d / 6'd10);
    units  = 4'(snap_d % 6'd10);
    digit  = (slot_d == SLOT_TENS) ? tens : units;

    blink_d = blink_q;
    phase_d = phase_q;
    if (!alarm || alarm_rise) begin
      blink_d = 10'd0;
      phase_d = PH_ON;
    end else if (scan_tick) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = 10'd0;
        phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        blink_d = blink_q + 10'd1;
      end
    end

    discode_d = seg;
    if (phase_d == PH_OFF || (slot_d == SLOT_TENS && tens == 4'd0)) begin
      discode_d = SEG_BLANK;
    end
    enable_d = (slot_d == SLOT_TENS) ? DIG_TENS : DIG_UNITS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q    <= 10'd0;
      blink_q   <= 10'd0;
      slot_q    <= SLOT_UNITS;
      phase_q   <= PH_ON;
      snap_q    <= 6'd0;
      alarm_q   <= 1'b0;
      discode_q <= SEG_BLANK;
      enable_q  <= DIG_NONE;
      frame_q   <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      blink_q   <= blink_d;
      slot_q    <= slot_d;
      phase_q   <= phase_d;
      snap_q    <= snap_d;
      alarm_q   <= alarm;
      discode_q <= discode_d;
      enable_q  <= enable_d;
      frame_q   <= frame_d;
    end
  end

  assign discode = discode_q;
  assign enable  = enable_q;
  assign frame   = frame_q;

endmodule
